// File: rtl/ram8_bist_pkg.sv
// rtl/ram8_bist_pkg.sv - shared widths and FSM state encodings for the ram8 BIST
//
// Purpose: common constants for ram8_bist and its pattern helper.
// Contents:
//   RAM8_DATA_W / RAM8_ADDR_W  word and address widths of the ram8 store
//   S_*                        3-bit BIST state encodings
package ram8_bist_pkg;

    localparam int RAM8_DATA_W = 16;
    localparam int RAM8_ADDR_W = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_C1_ADDR = 3'd2;
    localparam logic [2:0] S_C1_CHK  = 3'd3;
    localparam logic [2:0] S_C2_ADDR = 3'd4;
    localparam logic [2:0] S_C2_CHK  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/ram8_bist_pattern.sv
// rtl/ram8_bist_pattern.sv - march pattern generator D(a) = seed ^ a, optionally inverted
//
// Purpose: combinational pattern for one address of the march test.
// Ports:
//   seed  in   DATA_W  base pattern
//   addr  in   ADDR_W  word address, zero-extended into the pattern
//   inv   in   1       1 = return ~D(a)
//   data  out  DATA_W  D(a) or ~D(a)
module ram8_bist_pattern
    import ram8_bist_pkg::*;
#(
    parameter int DATA_W = RAM8_DATA_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] addr,
    input  logic              inv,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] base;

    assign base = seed ^ {{(DATA_W-ADDR_W){1'b0}}, addr};
    assign data = inv ? ~base : base;

endmodule

// File: rtl/ram8_bist.sv
// rtl/ram8_bist.sv - 3-phase march BIST initiator for the 8x16 ram8 store
//
// Purpose: on start, fills the RAM with D(a), checks and inverts ascending,
// then checks ~D(a) descending; reports pass and the first failing address.
// Optional build macro: RAM8_BIST_STOP_ON_FAIL_EN (end the run at the first miscompare).
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous active-high reset
//   start         in   1       begin test (sampled only in IDLE)
//   seed          in   DATA_W  base pattern, latched with start
//   mem_addr      out  ADDR_W  ram8 address
//   mem_data_in   out  DATA_W  ram8 write data
//   mem_we        out  1       ram8 write enable
//   mem_data_out  in   DATA_W  ram8 read data
//   busy          out  1       test in progress
//   done          out  1       one-cycle pulse at test end
//   pass          out  1       last run had no miscompare
//   fail_addr     out  ADDR_W  first miscompare address of the last run
module ram8_bist
    import ram8_bist_pkg::*;
#(
    parameter int DATA_W = RAM8_DATA_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr
);

`ifdef RAM8_BIST_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [2:0]        state;
    logic [2:0]        nstate;
    logic [ADDR_W-1:0] naddr;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] seed_src;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] wr_data;
    logic              err_seen;
    logic              accept;
    logic              chk;
    logic              miscmp;
    logic              exp_inv;
    logic              wr_inv;
    logic              nwe;

    assign accept  = (state == S_IDLE) && start;
    assign chk     = (state == S_C1_CHK) || (state == S_C2_CHK);
    assign exp_inv = (state == S_C2_CHK);
    assign miscmp  = chk && (mem_data_out != exp_data);

    // The first fill write is registered on the start edge itself, before
    // seed_q holds the new seed, so the write pattern takes the live input then.
    assign seed_src = accept ? seed : seed_q;
    assign wr_inv   = (nstate == S_C1_CHK);
    assign nwe      = (nstate == S_FILL) || (nstate == S_C1_CHK);

    // Expected read-back for the address currently being checked.
    ram8_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp (
        .seed (seed_q),
        .addr (mem_addr),
        .inv  (exp_inv),
        .data (exp_data)
    );

    // Write data for the cycle about to start (outputs are registered).
    ram8_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr (
        .seed (seed_src),
        .addr (naddr),
        .inv  (wr_inv),
        .data (wr_data)
    );

    // mem_addr doubles as the march address counter.
    always_comb begin
        nstate = state;
        naddr  = mem_addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nstate = S_FILL;
                    naddr  = '0;
                end
            end
            S_FILL: begin
                if (mem_addr == ADDR_MAX) begin
                    nstate = S_C1_ADDR;
                    naddr  = '0;
                end else begin
                    naddr = mem_addr + ADDR_W'(1);
                end
            end
            S_C1_ADDR: nstate = S_C1_CHK;
            S_C1_CHK: begin
                if (miscmp && STOP_ON_FAIL) begin
                    nstate = S_DONE;
                end else if (mem_addr == ADDR_MAX) begin
                    // descending phase starts from the top, address held
                    nstate = S_C2_ADDR;
                end else begin
                    nstate = S_C1_ADDR;
                    naddr  = mem_addr + ADDR_W'(1);
                end
            end
            S_C2_ADDR: nstate = S_C2_CHK;
            S_C2_CHK: begin
                if ((miscmp && STOP_ON_FAIL) || (mem_addr == '0)) begin
                    nstate = S_DONE;
                end else begin
                    nstate = S_C2_ADDR;
                    naddr  = mem_addr - ADDR_W'(1);
                end
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            seed_q      <= '0;
            err_seen    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
        end else begin
            state       <= nstate;
            mem_addr    <= naddr;
            mem_we      <= nwe;
            mem_data_in <= nwe ? wr_data : '0;
            busy        <= (nstate != S_IDLE) && (nstate != S_DONE);
            done        <= (nstate == S_DONE);

            if (accept) begin
                seed_q    <= seed;
                err_seen  <= 1'b0;
                pass      <= 1'b0;
                fail_addr <= '0;
            end

            if (miscmp) begin
                err_seen <= 1'b1;
                if (!err_seen) begin
                    fail_addr <= mem_addr;
                end
            end

            // include a miscompare on the very last check of the run
            if (nstate == S_DONE) begin
                pass <= !(err_seen || miscmp);
            end
        end
    end

endmodule

// File: tb/tb_ram8_bist.sv
// tb/tb_ram8_bist.sv - self-checking bench for ram8_bist with a behavioural ram8 responder
module tb_ram8_bist;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_we;
    logic [15:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_addr;

    int vectors = 0;
    int errors  = 0;

`ifdef RAM8_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    always #5 clk = ~clk;

    ram8_bist dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr)
    );

    // ram8 responder: synchronous write, registered read, per-address stuck-at-0 read mask
    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] mem   [8];
    logic [15:0] stuck [8];
    logic [15:0] rd_q;
    logic [2:0]  rd_a;
    wr_t         wlog  [$];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data_in;
            wlog.push_back({mem_addr, mem_data_in});
        end
        rd_q <= mem[mem_addr];
        rd_a <= mem_addr;
    end

    assign mem_data_out = rd_q & ~stuck[rd_a];

    // Reference march: 8 fill writes, then 16 checks of 2 cycles each; done one cycle later.
    function automatic void model(input logic [15:0] s, output bit p,
                                  output logic [2:0] fa, output int dc);
        logic [15:0] m [8];
        logic [15:0] rd;
        logic [15:0] ev;
        bit          err;
        int          a;
        err = 1'b0;
        fa  = 3'd0;
        dc  = 41;
        for (int i = 0; i < 8; i++) m[i] = s ^ 16'(i);
        for (int step = 0; step < 16; step++) begin
            a  = (step < 8) ? step : 15 - step;
            ev = (step < 8) ? (s ^ 16'(a)) : ~(s ^ 16'(a));
            rd = m[a] & ~stuck[a];
            if (step < 8) m[a] = ~(s ^ 16'(a));
            if (rd != ev && !err) begin
                err = 1'b1;
                fa  = 3'(a);
                if (STOP) begin
                    dc = 8 + 2 * (step + 1) + 1;
                    break;
                end
            end
        end
        p = !err;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stuck();
        for (int i = 0; i < 8; i++) stuck[i] = 16'h0000;
    endtask

    // One run from IDLE; cyc = cycle number (1 = first after the start edge) in which done is seen.
    task automatic run(input logic [15:0] s, output int cyc);
        wlog.delete();
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
        seed  = 16'($urandom);
        cyc   = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        seed  = 16'h0000;
        tick();
        tick();
        vectors += 7;
        if (mem_addr !== 3'd0)        begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        if (mem_data_in !== 16'h0000) begin errors++; $display("FAIL reset_mem_data_in got %h want 0", mem_data_in); end
        if (mem_we !== 1'b0)          begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)            begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (pass !== 1'b0)            begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        if (fail_addr !== 3'd0)       begin errors++; $display("FAIL reset_fail_addr got %h want 0", fail_addr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fixed_patterns();
        int cyc;
        clear_stuck();
        run(16'hAAAA, cyc);
        vectors += 4;
        if (cyc != 41)          begin errors++; $display("FAIL aaaa_done_cycle got %0d want 41", cyc); end
        if (pass !== 1'b1)      begin errors++; $display("FAIL aaaa_pass got %b want 1", pass); end
        if (fail_addr !== 3'd0) begin errors++; $display("FAIL aaaa_fail_addr got %h want 0", fail_addr); end
        if (mem[3] !== 16'h5556) begin errors++; $display("FAIL aaaa_ram3 got %h want 5556", mem[3]); end
        tick();

        run(16'h0000, cyc);
        vectors += 2;
        if (cyc != 41)     begin errors++; $display("FAIL zero_done_cycle got %0d want 41", cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass got %b want 1", pass); end
        for (int i = 0; i < 8; i++) begin
            vectors += 2;
            if (wlog.size() < 8 || wlog[i] !== {3'(i), 16'(i)}) begin
                errors++;
                $display("FAIL zero_fill_write%0d got %h want %h", i, (wlog.size() > i) ? wlog[i] : '0, {3'(i), 16'(i)});
            end
            if (mem[i] !== 16'hFFFF - 16'(i)) begin
                errors++;
                $display("FAIL zero_readback%0d got %h want %h", i, mem[i], 16'hFFFF - 16'(i));
            end
        end
        tick();
    endtask

    task automatic test_fault_addr2();
        int cyc;
        int exp_cyc;
        clear_stuck();
        stuck[2] = 16'h0020;
        exp_cyc  = STOP ? 15 : 41;
        run(16'hFFFF, cyc);
        vectors += 3;
        if (cyc != exp_cyc)     begin errors++; $display("FAIL fault_done_cycle got %0d want %0d", cyc, exp_cyc); end
        if (pass !== 1'b0)      begin errors++; $display("FAIL fault_pass got %b want 0", pass); end
        if (fail_addr !== 3'd2) begin errors++; $display("FAIL fault_fail_addr got %h want 2", fail_addr); end
        repeat (6) tick();
        vectors += 3;
        if (busy !== 1'b0)      begin errors++; $display("FAIL fault_idle_busy got %b want 0", busy); end
        if (pass !== 1'b0)      begin errors++; $display("FAIL fault_pass_hold got %b want 0", pass); end
        if (fail_addr !== 3'd2) begin errors++; $display("FAIL fault_fail_addr_hold got %h want 2", fail_addr); end
        clear_stuck();
    endtask

    task automatic test_reset_midrun();
        int cyc;
        clear_stuck();
        start = 1'b1;
        seed  = 16'($urandom);
        tick();
        start = 1'b0;
        repeat (11) tick();
        vectors += 2;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL midrun_we_before got %b want 1", mem_we); end
        if (busy !== 1'b1)   begin errors++; $display("FAIL midrun_busy_before got %b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors += 3;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL midrun_we_after got %b want 0", mem_we); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL midrun_busy_after got %b want 0", busy); end
        if (pass !== 1'b0)   begin errors++; $display("FAIL midrun_pass_after got %b want 0", pass); end
        tick();
        run(16'($urandom), cyc);
        vectors += 2;
        if (cyc != 41)     begin errors++; $display("FAIL rerun_done_cycle got %0d want 41", cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got %b want 1", pass); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        clear_stuck();
        start = 1'b1;
        seed  = 16'($urandom);
        tick();
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        vectors++;
        if (n != 41) begin errors++; $display("FAIL b2b_first got %0d want 41", n); end
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin tick(); n++; end while (!done && n < 200);
            vectors += 2;
            if (n != 42)       begin errors++; $display("FAIL b2b_period%0d got %0d want 42", r, n); end
            if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass%0d got %b want 1", r, pass); end
        end
        start = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy got %b want 0", busy); end
    endtask

    task automatic test_start_while_busy();
        int n;
        int dones;
        clear_stuck();
        start = 1'b1;
        seed  = 16'($urandom);
        tick();
        n = 1;
        while (!done && n < 200) begin
            start = (n == 5 || n == 20 || n == 33);
            tick();
            n++;
        end
        vectors++;
        if (n != 41) begin errors++; $display("FAIL busy_start_done got %0d want 41", n); end
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        repeat (10) begin
            if (busy || done) dones++;
            tick();
        end
        vectors++;
        if (dones != 0) begin errors++; $display("FAIL busy_start_retrigger got %0d active cycles want 0", dones); end
    endtask

    task automatic test_random();
        int          cyc;
        bit          ep;
        logic [2:0]  efa;
        int          edc;
        logic [15:0] s;
        bit          faulty;
        for (int it = 0; it < 10; it++) begin
            clear_stuck();
            faulty = ($urandom_range(0, 2) != 0);
            if (faulty) stuck[$urandom_range(0, 7)] = 16'h0001 << $urandom_range(0, 15);
            if (faulty && $urandom_range(0, 1) == 1) stuck[$urandom_range(0, 7)] = 16'h0001 << $urandom_range(0, 15);
            s = 16'($urandom);
            model(s, ep, efa, edc);
            run(s, cyc);
            vectors += 3;
            if (cyc != edc)        begin errors++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", it, cyc, edc); end
            if (pass !== ep)       begin errors++; $display("FAIL rnd%0d_pass got %b want %b", it, pass, ep); end
            if (fail_addr !== efa) begin errors++; $display("FAIL rnd%0d_fail_addr got %h want %h", it, fail_addr, efa); end
            if (!faulty) begin
                vectors++;
                if (wlog.size() != 16) begin
                    errors++;
                    $display("FAIL rnd%0d_write_count got %0d want 16", it, wlog.size());
                end else begin
                    for (int i = 0; i < 16; i++) begin
                        vectors++;
                        if (wlog[i] !== ((i < 8) ? {3'(i), s ^ 16'(i)} : {3'(i - 8), ~(s ^ 16'(i - 8))})) begin
                            errors++;
                            $display("FAIL rnd%0d_write%0d got %h", it, i, wlog[i]);
                        end
                    end
                end
            end
            tick();
        end
        clear_stuck();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = 16'h0000;
        clear_stuck();
        test_reset();
        test_fixed_patterns();
        test_fault_addr2();
        test_reset_midrun();
        test_back_to_back();
        test_start_while_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
